// File: rtl/issue_unit_pkg.sv
// Shared types and constants for the issue scheduler: source ids, default unit latencies,
// and the round-robin search order helper.
package issue_unit_pkg;

  typedef logic [1:0] src_t;

  localparam src_t SRC_INT  = 2'd0;
  localparam src_t SRC_LDST = 2'd1;
  localparam src_t SRC_MUL  = 2'd2;

  localparam int unsigned DEF_INT_LAT = 1;
  localparam int unsigned DEF_LS_LAT  = 2;
  localparam int unsigned DEF_MUL_LAT = 4;

  // Source examined at position `step` of a search that starts just after `last`.
  function automatic src_t rr_pick(src_t last, int unsigned step);
    int unsigned v;
    v = (32'(last) + 32'd1 + step) % 32'd3;
    return v[1:0];
  endfunction

endpackage

// File: rtl/issue_unit_rr_arbiter3.sv
// Three-way round-robin arbiter: the first request after `last` (int -> ld_st -> mul, wrapping)
// wins. Purely combinational; the caller owns the last-grant pointer.
module rr_arbiter3
  import issue_unit_pkg::*;
(
  input  logic [2:0] req,
  input  src_t       last,
  output logic [2:0] gnt,
  output src_t       gnt_id,
  output logic       gnt_valid
);

  src_t cand;

  always_comb begin
    gnt       = '0;
    gnt_id    = SRC_INT;
    gnt_valid = 1'b0;
    cand      = SRC_INT;
    for (int unsigned i = 0; i < 3; i++) begin
      cand = rr_pick(last, i);
      if (!gnt_valid && req[cand]) begin
        gnt_valid = 1'b1;
        gnt_id    = cand;
        gnt[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/issue_unit.sv
// Issue scheduler: grants one ready queue per cycle in round-robin order, restricted to sources
// whose fixed latency lands on a free CDB cycle, and drives the registered CDB source select.
module issue_unit
  import issue_unit_pkg::*;
#(
  parameter int unsigned INT_LAT = DEF_INT_LAT,
  parameter int unsigned LS_LAT  = DEF_LS_LAT,
  parameter int unsigned MUL_LAT = DEF_MUL_LAT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             issueque_int_ready,
  input  logic             issueque_ld_st_ready,
  input  logic             issueque_mul_ready,
  input  logic             issue_hold,
  output logic             issue_int,
  output logic             issue_ld_st,
  output logic             issue_mul,
  output logic             cdb_valid,
  output logic [1:0]       cdb_src,
  output logic [MUL_LAT:0] cdb_rsv
);

  // One-hot slot masks: bit L marks the CDB cycle L cycles from now.
  localparam logic [MUL_LAT:0] INT_SLOT = (MUL_LAT + 1)'(1) << INT_LAT;
  localparam logic [MUL_LAT:0] LS_SLOT  = (MUL_LAT + 1)'(1) << LS_LAT;
  localparam logic [MUL_LAT:0] MUL_SLOT = (MUL_LAT + 1)'(1) << MUL_LAT;

  logic [MUL_LAT:0] rsv_q, rsv_d;
  src_t             own_q [MUL_LAT+1];
  src_t             own_d [MUL_LAT+1];
  src_t             rr_last_q, rr_last_d;

  logic             can_issue;
  logic [2:0]       req, gnt;
  src_t             gnt_id;
  logic             gnt_valid;
  logic [MUL_LAT:0] new_slot;

  assign can_issue = !issue_hold && !reset;

  always_comb begin
    req           = '0;
    req[SRC_INT]  = issueque_int_ready   && !(|(rsv_q & INT_SLOT)) && can_issue;
    req[SRC_LDST] = issueque_ld_st_ready && !(|(rsv_q & LS_SLOT))  && can_issue;
    req[SRC_MUL]  = issueque_mul_ready   && !(|(rsv_q & MUL_SLOT)) && can_issue;
  end

  rr_arbiter3 u_arb (
    .req       (req),
    .last      (rr_last_q),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid)
  );

  always_comb begin
    new_slot = '0;
    if (gnt_valid) begin
      unique case (gnt_id)
        SRC_LDST: new_slot = LS_SLOT;
        SRC_MUL:  new_slot = MUL_SLOT;
        default:  new_slot = INT_SLOT;
      endcase
    end
  end

  // Everything advances one slot per cycle; the new reservation lands one slot closer as well.
  always_comb begin
    rsv_d            = (rsv_q >> 1) | (new_slot >> 1);
    own_d[MUL_LAT]   = SRC_INT;
    for (int unsigned k = 0; k < MUL_LAT; k++) begin
      own_d[k] = new_slot[k+1] ? gnt_id : own_q[k+1];
    end
    rr_last_d = gnt_valid ? gnt_id : rr_last_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rsv_q     <= '0;
      own_q     <= '{default: SRC_INT};
      rr_last_q <= SRC_MUL;
    end else begin
      rsv_q     <= rsv_d;
      own_q     <= own_d;
      rr_last_q <= rr_last_d;
    end
  end

  assign issue_int   = gnt[SRC_INT];
  assign issue_ld_st = gnt[SRC_LDST];
  assign issue_mul   = gnt[SRC_MUL];
  assign cdb_valid   = rsv_q[0] && !reset;
  assign cdb_src     = reset ? SRC_INT : own_q[0];
  assign cdb_rsv     = rsv_q;

endmodule

// File: tb/tb_issue_unit.sv
// Bench for issue_unit: a default instance and an INT_LAT == LS_LAT instance share stimulus and
// are checked every cycle against a CDB booking-calendar model, plus literal directed checks.
module tb_issue_unit;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic r_int = 1'b0, r_ls = 1'b0, r_mul = 1'b0, hold = 1'b0;

  logic       a_int, a_ls, a_mul, a_cv;
  logic [1:0] a_cs;
  logic [4:0] a_rsv;
  logic       b_int, b_ls, b_mul, b_cv;
  logic [1:0] b_cs;
  logic [4:0] b_rsv;

  always #5 clock = ~clock;

  issue_unit dut (
    .clock                (clock),
    .reset                (reset),
    .issueque_int_ready   (r_int),
    .issueque_ld_st_ready (r_ls),
    .issueque_mul_ready   (r_mul),
    .issue_hold           (hold),
    .issue_int            (a_int),
    .issue_ld_st          (a_ls),
    .issue_mul            (a_mul),
    .cdb_valid            (a_cv),
    .cdb_src              (a_cs),
    .cdb_rsv              (a_rsv)
  );

  issue_unit #(.INT_LAT(2), .LS_LAT(2), .MUL_LAT(4)) dut_eq (
    .clock                (clock),
    .reset                (reset),
    .issueque_int_ready   (r_int),
    .issueque_ld_st_ready (r_ls),
    .issueque_mul_ready   (r_mul),
    .issue_hold           (hold),
    .issue_int            (b_int),
    .issue_ld_st          (b_ls),
    .issue_mul            (b_mul),
    .cdb_valid            (b_cv),
    .cdb_src              (b_cs),
    .cdb_rsv              (b_rsv)
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: an absolute-cycle calendar of booked CDB cycles and their owners.
  bit  bk [2][0:1023];
  int  ow [2][0:1023];
  int  last_m [2] = '{2, 2};
  int  lat [2][3] = '{'{1, 2, 4}, '{2, 2, 4}};
  int  cyc = 0;

  always @(negedge clock) begin : model
    int         gid;
    int         s;
    logic [2:0] rdy, exp_g, got_g;
    logic [4:0] exp_rsv, got_rsv;
    logic       exp_cv, got_cv;
    logic [1:0] exp_cs, got_cs;
    rdy = {r_mul, r_ls, r_int};
    for (int m = 0; m < 2; m++) begin
      gid = -1;
      if (!reset && !hold) begin
        for (int i = 0; i < 3; i++) begin
          s = (last_m[m] + 1 + i) % 3;
          if (gid < 0 && rdy[s] && !bk[m][cyc + lat[m][s]]) gid = s;
        end
      end
      exp_g  = (gid >= 0) ? 3'(1 << gid) : 3'b000;
      exp_cv = !reset && bk[m][cyc];
      exp_cs = exp_cv ? 2'(ow[m][cyc]) : 2'd0;
      for (int k = 0; k < 5; k++) exp_rsv[k] = bk[m][cyc + k];
      got_g   = (m == 0) ? {a_mul, a_ls, a_int} : {b_mul, b_ls, b_int};
      got_cv  = (m == 0) ? a_cv : b_cv;
      got_cs  = (m == 0) ? a_cs : b_cs;
      got_rsv = (m == 0) ? a_rsv : b_rsv;
      chk($sformatf("m%0d grant c%0d", m, cyc), 32'(got_g), 32'(exp_g));
      chk($sformatf("m%0d cdb_valid c%0d", m, cyc), 32'(got_cv), 32'(exp_cv));
      chk($sformatf("m%0d cdb_src c%0d", m, cyc), 32'(got_cs), 32'(exp_cs));
      chk($sformatf("m%0d cdb_rsv c%0d", m, cyc), 32'(got_rsv), 32'(exp_rsv));
      if (reset) begin
        for (int k = 1; k <= 5; k++) bk[m][cyc + k] = 1'b0;
        last_m[m] = 2;
      end else if (gid >= 0) begin
        bk[m][cyc + lat[m][gid]] = 1'b1;
        ow[m][cyc + lat[m][gid]] = gid;
        last_m[m] = gid;
      end
    end
    cyc++;
  end

  // Per-test recordings, index 0 = first cycle after the reset sequence.
  logic [2:0] ga [0:31];
  logic [2:0] gb [0:31];
  logic       va [0:31];
  logic       vb [0:31];
  logic [1:0] sa [0:31];
  logic [1:0] sb [0:31];
  logic [4:0] ra [0:31];
  int         n = 0;

  task automatic cyc_in(input bit ri, input bit rl, input bit rm, input bit h, input bit rs);
    @(posedge clock);
    #1;
    r_int = ri; r_ls = rl; r_mul = rm; hold = h; reset = rs;
    @(negedge clock);
    ga[n] = {a_mul, a_ls, a_int};
    gb[n] = {b_mul, b_ls, b_int};
    va[n] = a_cv;
    vb[n] = b_cv;
    sa[n] = a_cs;
    sb[n] = b_cs;
    ra[n] = a_rsv;
    n++;
  endtask

  task automatic do_reset();
    n = 0;
    cyc_in(1, 1, 1, 0, 1);
    cyc_in(1, 1, 1, 0, 1);
    chk("reset grants gated", 32'(ga[1]), 32'd0);
    chk("reset cdb_valid", 32'(va[1]), 32'd0);
    n = 0;
  endtask

  initial begin
    // 1: reset state, lone int request
    do_reset();
    cyc_in(1, 0, 0, 0, 0);
    cyc_in(0, 0, 0, 0, 0);
    cyc_in(0, 0, 0, 0, 0);
    chk("t1 rsv after reset", 32'(ra[0]), 32'd0);
    chk("t1 int grant", 32'(ga[0]), 32'd1);
    chk("t1 cdb_valid t1", 32'(va[1]), 32'd1);
    chk("t1 cdb_src t1", 32'(sa[1]), 32'd0);
    chk("t1 cdb idle t2", 32'(va[2]), 32'd0);

    // 2: all ready continuously
    do_reset();
    for (int i = 0; i < 12; i++) cyc_in(1, 1, 1, 0, 0);
    chk("t2 g0 int", 32'(ga[0]), 32'd1);
    chk("t2 g1 ldst", 32'(ga[1]), 32'd2);
    chk("t2 g2 mul", 32'(ga[2]), 32'd4);
    chk("t2 g3 int", 32'(ga[3]), 32'd1);
    chk("t2 g4 mul (ldst slot taken)", 32'(ga[4]), 32'd4);
    chk("t2 g5 ldst (int slot taken)", 32'(ga[5]), 32'd2);
    chk("t2 cdb_src t1", 32'(sa[1]), 32'd0);
    chk("t2 cdb_src t3", 32'(sa[3]), 32'd1);

    // 3: ld_st blocked by an earlier mul reservation
    do_reset();
    cyc_in(0, 0, 1, 0, 0);
    cyc_in(0, 0, 0, 0, 0);
    cyc_in(0, 1, 0, 0, 0);
    cyc_in(0, 1, 0, 0, 0);
    cyc_in(0, 0, 0, 0, 0);
    cyc_in(0, 0, 0, 0, 0);
    chk("t3 mul grant", 32'(ga[0]), 32'd4);
    chk("t3 ldst blocked t2", 32'(ga[2]), 32'd0);
    chk("t3 ldst grant t3", 32'(ga[3]), 32'd2);
    chk("t3 cdb_valid t4", 32'(va[4]), 32'd1);
    chk("t3 cdb_src t4", 32'(sa[4]), 32'd2);
    chk("t3 cdb_valid t5", 32'(va[5]), 32'd1);
    chk("t3 cdb_src t5", 32'(sa[5]), 32'd1);

    // 4: issue_hold
    do_reset();
    cyc_in(1, 1, 1, 0, 0);
    cyc_in(1, 1, 1, 1, 0);
    cyc_in(1, 1, 1, 0, 0);
    cyc_in(0, 0, 0, 0, 0);
    chk("t4 int grant", 32'(ga[0]), 32'd1);
    chk("t4 hold no grant", 32'(ga[1]), 32'd0);
    chk("t4 cdb_valid under hold", 32'(va[1]), 32'd1);
    chk("t4 cdb_src under hold", 32'(sa[1]), 32'd0);
    chk("t4 resume ldst", 32'(ga[2]), 32'd2);

    // 5: equal int/ld_st latency on dut_eq
    do_reset();
    for (int i = 0; i < 4; i++) cyc_in(1, 1, 0, 0, 0);
    cyc_in(0, 0, 0, 0, 0);
    cyc_in(0, 0, 0, 0, 0);
    chk("t5 g0 int", 32'(gb[0]), 32'd1);
    chk("t5 g1 ldst", 32'(gb[1]), 32'd2);
    chk("t5 g2 int", 32'(gb[2]), 32'd1);
    chk("t5 g3 ldst", 32'(gb[3]), 32'd2);
    chk("t5 cdb_valid t2", 32'(vb[2]), 32'd1);
    chk("t5 cdb_src t2", 32'(sb[2]), 32'd0);
    chk("t5 cdb_src t3", 32'(sb[3]), 32'd1);
    chk("t5 cdb_src t4", 32'(sb[4]), 32'd0);
    chk("t5 cdb_src t5", 32'(sb[5]), 32'd1);

    // 6: reset mid-operation discards reservations
    do_reset();
    cyc_in(1, 1, 1, 0, 0);
    cyc_in(1, 1, 1, 0, 0);
    cyc_in(1, 1, 1, 0, 1);
    for (int i = 0; i < 5; i++) cyc_in(0, 0, 0, 0, 0);
    cyc_in(1, 1, 1, 0, 0);
    cyc_in(0, 0, 0, 0, 0);
    chk("t6 cdb_valid t1", 32'(va[1]), 32'd1);
    chk("t6 no grant in reset", 32'(ga[2]), 32'd0);
    chk("t6 rsv cleared", 32'(ra[3]), 32'd0);
    for (int i = 3; i < 8; i++) chk($sformatf("t6 cdb idle t%0d", i), 32'(va[i]), 32'd0);
    chk("t6 first grant int", 32'(ga[8]), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
